// File: rtl/multiplier_seq_pkg.sv
// Shared definitions for the sequential arithmetic units.
// Holds the state encoding and the iteration counter width.
package multiplier_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/multiplier_seq_dp.sv
// Shift/add datapath of the sequential multiplier.
// Holds the shifted operands, the accumulator and the iteration count.
module multiplier_seq_dp
    import multiplier_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               last,
    output logic [2*WIDTH-1:0] sum
);

    localparam int CW = cnt_w(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // sum already includes this cycle's addend, so it is the final
    // product when last is high
    always_comb begin
        sum  = mplier_q[0] ? acc_q + mcand_q : acc_q;
        last = (cnt_q == CW'(1)) ||
               (EARLY_EXIT && ((mplier_q >> 1) == '0));
    end

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, multiplicand};
            acc_d    = '0;
            mplier_d = multiplier;
            cnt_d    = CW'(WIDTH);
        end else if (step) begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/multiplier_seq.sv
// Sequential shift-and-add unsigned multiplier with start/valid handshake.
// Control FSM, result registers and valid generation live here.
module multiplier_seq
    import multiplier_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit INIT_VLD   = 1'b0,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow,
    output logic               busy,
    output logic               valid
);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               overflow_q, overflow_d;
    logic               valid_en_q, valid_en_d;
    logic               load, step, last;
    logic               zero_op;
    logic [2*WIDTH-1:0] sum;

    multiplier_seq_dp #(
        .WIDTH      (WIDTH),
        .EARLY_EXIT (EARLY_EXIT)
    ) u_dp (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .step         (step),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .last         (last),
        .sum          (sum)
    );

    assign zero_op = (multiplicand == '0) || (multiplier == '0);
    assign step    = (state_q == CALC);

    always_comb begin
        state_d    = state_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        valid_en_d = valid_en_q;
        load       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    valid_en_d = 1'b1;
                    // a zero operand resolves on the accept edge itself
                    if (zero_op) begin
                        product_d  = '0;
                        overflow_d = 1'b0;
                    end else begin
                        load    = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (last) begin
                    product_d  = sum;
                    overflow_d = |sum[2*WIDTH-1:WIDTH];
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            product_q  <= '0;
            overflow_q <= 1'b0;
            valid_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
            valid_en_q <= valid_en_d;
        end
    end

    assign product  = product_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == CALC);
    assign valid    = (INIT_VLD || valid_en_q) && (state_q == IDLE) && !start;

endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench for multiplier_seq at WIDTH=8, with early exit
// on one instance and fixed latency plus INIT_VLD on the other.
module tb_multiplier_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sel = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic           start_ee, start_fx;
    logic [2*W-1:0] p_ee, p_fx;
    logic           ov_ee, ov_fx, bz_ee, bz_fx, vl_ee, vl_fx;

    int total = 0;
    int bad   = 0;

    assign start_ee = start && !sel;
    assign start_fx = start && sel;

    always #5 clk = ~clk;

    multiplier_seq #(.WIDTH(W), .INIT_VLD(1'b0), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst(rst), .start(start_ee),
        .multiplicand(a), .multiplier(b),
        .product(p_ee), .overflow(ov_ee), .busy(bz_ee), .valid(vl_ee)
    );

    multiplier_seq #(.WIDTH(W), .INIT_VLD(1'b1), .EARLY_EXIT(1'b0)) u_fx (
        .clk(clk), .rst(rst), .start(start_fx),
        .multiplicand(a), .multiplier(b),
        .product(p_fx), .overflow(ov_fx), .busy(bz_fx), .valid(vl_fx)
    );

    wire [2*W-1:0] p_s  = sel ? p_fx  : p_ee;
    wire           ov_s = sel ? ov_fx : ov_ee;
    wire           bz_s = sel ? bz_fx : bz_ee;
    wire           vl_s = sel ? vl_fx : vl_ee;

    // reference: exact product, cycles = WIDTH or position of top set bit + 1
    function automatic int ref_cycles(input logic s, input logic [W-1:0] x,
                                      input logic [W-1:0] y);
        if (x == 0 || y == 0) return 0;
        if (s) return W;
        return $clog2(int'(y) + 1);
    endfunction

    task automatic run_op(input logic s, input logic [W-1:0] x,
                          input logic [W-1:0] y, input string nm);
        logic [2*W-1:0] prev, expp;
        int expc, cyc;
        sel = s;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        prev = p_s;
        expp = (2*W)'(int'(x) * int'(y));
        expc = ref_cycles(s, x, y);
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (bz_s && cyc < 40) begin
            total++;
            if (p_s !== prev) begin
                bad++;
                $display("FAIL %s hold: product=%h required %h", nm, p_s, prev);
            end
            cyc++;
            @(negedge clk);
        end
        total++;
        if (cyc !== expc) begin
            bad++;
            $display("FAIL %s cycles: got %0d required %0d", nm, cyc, expc);
        end
        total++;
        if (p_s !== expp) begin
            bad++;
            $display("FAIL %s product: got %h required %h", nm, p_s, expp);
        end
        total++;
        if (ov_s !== (expp[2*W-1:W] != 0)) begin
            bad++;
            $display("FAIL %s overflow: got %b required %b", nm, ov_s,
                     expp[2*W-1:W] != 0);
        end
        total++;
        if (vl_s !== 1'b1) begin
            bad++;
            $display("FAIL %s valid: got %b required 1", nm, vl_s);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (p_ee !== 16'h0 || ov_ee !== 1'b0 || bz_ee !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs: p=%h ov=%b busy=%b required 0/0/0",
                     p_ee, ov_ee, bz_ee);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (vl_ee !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid_ee: got %b required 0", vl_ee);
        end
        total++;
        if (vl_fx !== 1'b1) begin
            bad++;
            $display("FAIL reset_valid_fx: got %b required 1", vl_fx);
        end
    endtask

    task automatic test_basic();
        run_op(1'b0, 8'd6, 8'd7, "ee_6x7");
        run_op(1'b0, 8'd255, 8'd255, "ee_255x255");
        run_op(1'b1, 8'd255, 8'd255, "fx_255x255");
        run_op(1'b1, 8'd1, 8'd1, "fx_1x1");
        run_op(1'b0, 8'd1, 8'd1, "ee_1x1");
    endtask

    task automatic test_zero();
        logic [8:0] wide;
        wide = 9'h123;
        run_op(1'b0, 8'd9, 8'd9, "ee_pre_zero");
        run_op(1'b0, wide[7:0], 8'd0, "ee_23x0");
        run_op(1'b0, 8'd0, 8'd45, "ee_0x45");
        run_op(1'b1, 8'd45, 8'd0, "fx_45x0");
    endtask

    task automatic test_ignore_start();
        int cyc;
        sel = 1'b0;
        @(negedge clk);
        a = 8'd3; b = 8'd4; start = 1'b1;
        @(posedge clk);
        #1 a = 8'd9; b = 8'd9;
        cyc = 0;
        @(negedge clk);
        while (bz_ee && cyc < 40) begin
            total++;
            if (vl_ee !== 1'b0) begin
                bad++;
                $display("FAIL ign_valid_calc: got %b required 0", vl_ee);
            end
            cyc++;
            @(negedge clk);
        end
        total++;
        if (cyc !== 3 || p_ee !== 16'd12 || vl_ee !== 1'b0) begin
            bad++;
            $display("FAIL ign_first: cyc=%0d p=%0d v=%b required 3/12/0",
                     cyc, p_ee, vl_ee);
        end
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (bz_ee && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        total++;
        if (cyc !== 4 || p_ee !== 16'd81 || vl_ee !== 1'b1) begin
            bad++;
            $display("FAIL ign_second: cyc=%0d p=%0d v=%b required 4/81/1",
                     cyc, p_ee, vl_ee);
        end
    endtask

    task automatic test_async_reset();
        sel = 1'b0;
        run_op(1'b0, 8'd17, 8'd19, "ee_pre_rst");
        @(negedge clk);
        a = 8'd100; b = 8'd200; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bz_ee !== 1'b1) begin
            bad++;
            $display("FAIL arst_busy_before: got %b required 1", bz_ee);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bz_ee !== 1'b0 || p_ee !== 16'h0 || vl_ee !== 1'b0 || ov_ee !== 1'b0) begin
            bad++;
            $display("FAIL arst_outs: busy=%b p=%h v=%b ov=%b required 0",
                     bz_ee, p_ee, vl_ee, ov_ee);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (vl_ee !== 1'b0) begin
            bad++;
            $display("FAIL arst_valid_after: got %b required 0", vl_ee);
        end
        run_op(1'b0, 8'd13, 8'd11, "ee_post_rst");
    endtask

    task automatic test_back_to_back();
        int cyc;
        sel = 1'b0;
        @(negedge clk);
        a = 8'd200; b = 8'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            total++;
            if (bz_ee !== 1'b1) begin
                bad++;
                $display("FAIL b2b_busy%0d: got %b required 1", k, bz_ee);
            end
            if (k == 2) begin
                a = 8'd10; b = 8'd10; start = 1'b1;
            end
        end
        @(negedge clk);
        total++;
        if (bz_ee !== 1'b0 || vl_ee !== 1'b0 || p_ee !== 16'd600 || ov_ee !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: busy=%b v=%b p=%0d ov=%b required 0/0/600/1",
                     bz_ee, vl_ee, p_ee, ov_ee);
        end
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (bz_ee && cyc < 40) begin
            total++;
            if (vl_ee !== 1'b0) begin
                bad++;
                $display("FAIL b2b_valid_calc: got %b required 0", vl_ee);
            end
            cyc++;
            @(negedge clk);
        end
        total++;
        if (cyc !== 4 || p_ee !== 16'd100 || ov_ee !== 1'b0 || vl_ee !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: cyc=%0d p=%0d ov=%b v=%b required 4/100/0/1",
                     cyc, p_ee, ov_ee, vl_ee);
        end
    endtask

    task automatic test_random();
        logic         s;
        logic [W-1:0] x, y;
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom % 2);
            x = W'($urandom);
            y = W'($urandom);
            if ($urandom % 8 == 0) y = '0;
            run_op(s, x, y, $sformatf("rnd%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiplier_seq.md
Name: multiplier_seq

Overview:
Sequential shift-and-add unsigned multiplier. It is the companion of the team's sequential divider and uses the same start/valid handshake style, so the two blocks can sit side by side behind one arithmetic front end. It produces a full 2*WIDTH-bit product plus an overflow flag for consumers that keep only the low half. Latency is data-dependent: at most WIDTH cycles, or fewer with early exit.

Parameters:
WIDTH, 32, operand width in bits (>=2)
INIT_VLD, 0, 1: valid may assert straight after reset; 0: valid only after the first accepted start
EARLY_EXIT, 1, 1: stop once the remaining multiplier bits are all zero; 0: always WIDTH CALC cycles

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
multiplicand  input  WIDTH  operand A, sampled on the accepted start edge
multiplier  input  WIDTH  operand B, sampled on the accepted start edge
product  output  2*WIDTH  registered result; holds the last result
overflow  output  1  registered; high when product[2*WIDTH-1:WIDTH] != 0
busy  output  1  state == CALC
valid  output  1  result available

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high; it takes effect immediately, including mid-operation.
- Reset values: state=IDLE, product=0, overflow=0, busy=0, valid_en=0 (INIT_VLD=0). Internal operand and accumulator registers are don't-care.
- States: IDLE, CALC, encoded in 1 bit.
- valid:
  - INIT_VLD=1: valid = (state==IDLE) && !start.
  - INIT_VLD=0: valid = valid_en && (state==IDLE) && !start; valid_en sets on the first accepted start and clears only on rst.
- Accept: a start edge in IDLE is accepted. start during CALC is ignored, and the operands are not resampled.
- Zero operand: if either operand is 0 at accept, product<=0 and overflow<=0 on that edge. State stays IDLE and valid rises the next cycle if start is low.
- Nonzero accept, on the same edge:
  - mcandOp(2*WIDTH) <= zero-extended multiplicand
  - mplierOp <= multiplier
  - acc <= 0
  - cnt <= WIDTH; cnt width is $clog2(WIDTH)+1
  - state <= CALC
- Each CALC cycle:
  - if mplierOp[0] then acc <= acc + mcandOp, with the sum truncated to 2*WIDTH bits (it never truncates in practice)
  - mcandOp <<= 1; mplierOp >>= 1; cnt <= cnt-1
- Completion: the last CALC cycle is the one with cnt==1, or, with EARLY_EXIT=1, the one where (mplierOp>>1)==0. On that edge:
  - product <= final acc (including the current addend)
  - overflow <= |final[2*WIDTH-1:WIDTH]
  - state <= IDLE
- Latency, start edge to the first valid cycle:
  - EARLY_EXIT=0: WIDTH+1 cycles.
  - EARLY_EXIT=1: (index of the multiplier MSB set)+2 cycles.
- product and overflow never change during CALC. They update only on a completion edge, a zero-operand accept, or rst.
- Back-to-back: start high in the first IDLE cycle after completion is accepted immediately. valid stays low that cycle because start is high.
- Width rules: all arithmetic is unsigned. The full product fits exactly in 2*WIDTH bits, so there is no wrap.

Decomposition:
- Shared arithmetic package/header: the state encodings (IDLE, CALC) and the counter-width constant $clog2(WIDTH)+1. These are shared with the divider.
- One natural sub-module: multiplier_seq_dp, the shift/add datapath (mcandOp, mplierOp, acc, cnt), with load, step and last outputs. The control FSM and valid logic stay in the top module.

Test Plan:
- WIDTH=8, EARLY_EXIT=1: rst, then start with 6x7 -> exactly 3 cycles with busy high; product=42 (0x002A); overflow=0; valid high the cycle after busy falls.
- WIDTH=8: 255x255 -> 8 CALC cycles; product=0xFE01; overflow=1. Repeat with EARLY_EXIT=0 and 1x1 -> 8 CALC cycles, product=1.
- WIDTH=8: 0x123 (low 8 bits 0x23) and 45x0 -> busy never asserts; product=0, overflow=0; valid the next cycle.
- Start 3x4; during CALC hold start high with 9x9 -> result is 12; valid stays low while start is high; 9x9 is accepted only after returning to IDLE.
- INIT_VLD=0: valid low after reset until the first op completes. Pulse rst asynchronously mid-CALC -> busy, product and valid drop to 0 without a clock edge; the next op works normally.
- Back-to-back: 200x3 completes, start 10x10 in the first IDLE cycle -> product=600, then 100; valid never high between the two ops.
